// File: rtl/rf_stim_gen_if.sv
// rf_stim_gen sample stream: valid/ready beat carrying NUM_CH packed channels.
// Master drives data/valid, slave returns ready.
interface rf_stim_gen_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 1
);
    logic [NUM_CH*DATA_WIDTH-1:0] out_data;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/rf_stim_gen.sv
// rf_stim_gen: multi-channel ramp / tone / LFSR / constant ADC stimulus.
// Define RF_STIM_GEN_CHECKSUM_EN to add the channel-0 checksum port.
module rf_stim_gen #(
    parameter int          DATA_WIDTH  = 16,
    parameter int          PHASE_WIDTH = 24,
    parameter int          NUM_CH      = 1,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode,
    input  logic [PHASE_WIDTH-1:0] phase_inc,
    input  logic [DATA_WIDTH-1:0]  amplitude,
    input  logic [31:0]            num_samples,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            sample_count,
`ifdef RF_STIM_GEN_CHECKSUM_EN
    output logic [31:0]            checksum,
`endif
    rf_stim_gen_if.master          out
);

    localparam int          DW   = DATA_WIDTH;
    localparam int          PW   = PHASE_WIDTH;
    localparam int          CHB  = $clog2(NUM_CH);
    localparam logic [31:0] POLY = 32'h8020_0003;

    if (NUM_CH != 1 && NUM_CH != 2 && NUM_CH != 4 && NUM_CH != 8)
    begin : g_bad_ch
        $error("rf_stim_gen: NUM_CH must be 1, 2, 4 or 8");
    end
    if (PW <= DW || DW < 8 || DW > 24) begin : g_bad_width
        $error("rf_stim_gen: need 8 <= DATA_WIDTH <= 24 < PHASE_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [PW-1:0]        acc_q;
    logic [PW-1:0]        acc_d;
    logic [PW-1:0]        inc_q;
    logic [DW-1:0]        ramp_q;
    logic [DW-1:0]        ramp_d;
    logic [DW-1:0]        amp_q;
    logic [DW-1:0]        amp_d;
    logic [1:0]           mode_q;
    logic [1:0]           mode_d;
    logic [31:0]          num_q;
    logic [31:0]          cnt_q;
    logic [31:0]          lfsr_q [NUM_CH];
    logic [31:0]          lfsr_d [NUM_CH];
    logic [NUM_CH*DW-1:0] data_q;
    logic [NUM_CH*DW-1:0] samp_d;
    logic                 done_q;

    logic go;
    logic vld;
    logic accept;
    logic last;
    logic fin;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    // Folded sawtooth gives a triangle, then scaled by signed amplitude.
    function automatic logic [DW-1:0] tone(
        input logic [PW-1:0] ph,
        input logic [DW-1:0] amp
    );
        logic        [DW-1:0]   u;
        logic        [DW-1:0]   t;
        logic signed [DW-1:0]   s;
        logic signed [2*DW-1:0] p;
        u = DW'(ph >> (PW - DW));
        t = u[DW-1] ? ~DW'(u << 1) : DW'(u << 1);
        s = $signed(t ^ {1'b1, {(DW-1){1'b0}}});
        p = s * $signed(amp);
        return DW'(p >>> (DW - 1));
    endfunction

    assign accept = vld && out.out_ready;
    assign last   = accept && (num_q != 32'd0)
                    && (cnt_q + 32'd1 == num_q);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over count completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    state_d = accept ? S_IDLE : S_FLUSH;
                end else if (last) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (accept) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q != S_IDLE);
        vld  = busy;
        go   = (state_q == S_IDLE) && start && !abort;
        fin  = busy && (state_d == S_IDLE);
    end

    // Generator state for the beat to present next.
    always_comb begin
        mode_d = go ? mode : mode_q;
        amp_d  = go ? amplitude : amp_q;
        acc_d  = acc_q;
        ramp_d = ramp_q;
        for (int k = 0; k < NUM_CH; k++) begin
            lfsr_d[k] = lfsr_q[k];
        end
        if (go) begin
            acc_d  = '0;
            ramp_d = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                lfsr_d[k] = LFSR_SEED ^ 32'(k);
            end
        end else if (accept) begin
            acc_d  = acc_q + inc_q;
            ramp_d = ramp_q + 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                lfsr_d[k] = lfsr_step(lfsr_q[k]);
            end
        end
    end

    always_comb begin
        samp_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            case (mode_d)
                2'd0: samp_d[k*DW +: DW] = ramp_d + DW'(k);
                2'd1: samp_d[k*DW +: DW] =
                    tone(acc_d + (PW'(k) << (PW - CHB)), amp_d);
                2'd2: samp_d[k*DW +: DW] = lfsr_d[k][DW-1:0];
                default: samp_d[k*DW +: DW] = amp_d;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            inc_q  <= '0;
            ramp_q <= '0;
            amp_q  <= '0;
            mode_q <= '0;
            num_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            done_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                lfsr_q[k] <= LFSR_SEED ^ 32'(k);
            end
        end else begin
            acc_q  <= acc_d;
            ramp_q <= ramp_d;
            amp_q  <= amp_d;
            mode_q <= mode_d;
            for (int k = 0; k < NUM_CH; k++) begin
                lfsr_q[k] <= lfsr_d[k];
            end
            if (go) begin
                inc_q <= phase_inc;
                num_q <= num_samples;
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (go || accept) data_q <= samp_d;
            done_q <= fin;
        end
    end

`ifdef RF_STIM_GEN_CHECKSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (go) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q + 32'(data_q[DW-1:0]);
        end
    end

    assign checksum = csum_q;
`endif

    assign out.out_data  = data_q;
    assign out.out_valid = vld;
    assign done          = done_q;
    assign sample_count  = cnt_q;

endmodule

// File: tb/tb_rf_stim_gen.sv
// Scoreboard bench for rf_stim_gen with four 16-bit channels.
// Expected beats are queued by the driver and popped by the monitor.
module tb_rf_stim_gen;

    localparam int DW  = 16;
    localparam int PW  = 24;
    localparam int NCH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [1:0]    mode;
    logic [PW-1:0] phase_inc;
    logic [DW-1:0] amplitude;
    logic [31:0]   num_samples;
    logic          busy;
    logic          done;
    logic [31:0]   sample_count;
`ifdef RF_STIM_GEN_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    rf_stim_gen_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

    rf_stim_gen #(
        .DATA_WIDTH (DW),
        .PHASE_WIDTH(PW),
        .NUM_CH     (NCH),
        .LFSR_SEED  (32'hACE1_0001)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .phase_inc   (phase_inc),
        .amplitude   (amplitude),
        .num_samples (num_samples),
        .busy        (busy),
        .done        (done),
        .sample_count(sample_count),
`ifdef RF_STIM_GEN_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .out         (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb [$];
    logic [63:0] exp_w;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [1:0] m, input logic [PW-1:0] inc,
                       input logic [DW-1:0] amp, input logic [31:0] n);
        mode        = m;
        phase_inc   = inc;
        amplitude   = amp;
        num_samples = n;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    function automatic logic [63:0] ramp_w(input int b);
        return {16'(b + 3), 16'(b + 2), 16'(b + 1), 16'(b)};
    endfunction

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat: got %h, expected no beat",
                         bus.out_data);
            end else begin
                exp_w = sb.pop_front();
                if (bus.out_data !== exp_w) begin
                    errors++;
                    $display("FAIL beat: got %h, expected %h",
                             bus.out_data, exp_w);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        mode          = 2'd0;
        phase_inc     = '0;
        amplitude     = '0;
        num_samples   = '0;
        bus.out_ready = 1'b1;
        tick(3);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", sample_count, 0);
        chk("rst_data", bus.out_data, 0);
`ifdef RF_STIM_GEN_CHECKSUM_EN
        chk("rst_checksum", checksum, 0);
`endif
        rst_n = 1'b1;
        tick();

        // Ramp, 4 beats, no backpressure
        for (int b = 0; b < 4; b++) sb.push_back(ramp_w(b));
        run(2'd0, '0, '0, 32'd4);
        chk("t1_first_beat", bus.out_data, 64'h0003_0002_0001_0000);
        chk("t1_valid", bus.out_valid, 1);
        tick(3);
        chk("t1_no_early_done", done, 0);
        chk("t1_busy_mid", busy, 1);
        tick();
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_valid_end", bus.out_valid, 0);
        chk("t1_count", sample_count, 4);
`ifdef RF_STIM_GEN_CHECKSUM_EN
        chk("t1_checksum", checksum, 6);
`endif
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_count_hold", sample_count, 4);
        chk("t1_drained", sb.size(), 0);

        // Ramp with 3-cycle stall at beat 1; start while busy is ignored
        for (int b = 0; b < 4; b++) sb.push_back(ramp_w(b));
        run(2'd0, '0, '0, 32'd4);
        tick();
        bus.out_ready = 1'b0;
        start         = 1'b1;
        mode          = 2'd3;
        amplitude     = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_stall_data", bus.out_data, ramp_w(1));
            chk("t2_stall_valid", bus.out_valid, 1);
        end
        start         = 1'b0;
        bus.out_ready = 1'b1;
        tick(2);
        chk("t2_no_early_done", done, 0);
        tick();
        chk("t2_done", done, 1);
        chk("t2_count", sample_count, 4);
`ifdef RF_STIM_GEN_CHECKSUM_EN
        chk("t2_checksum", checksum, 6);
`endif
        tick();
        chk("t2_idle", busy, 0);

        // Triangle tone, channels offset by a quarter turn each
        sb.push_back(64'hFFFF_7FFE_0000_8001);
        sb.push_back(64'h8001_FFFF_7FFE_0000);
        sb.push_back(64'h0000_8001_FFFF_7FFE);
        sb.push_back(64'h7FFE_0000_8001_FFFF);
        run(2'd1, 24'h40_0000, 16'h7FFF, 32'd4);
        tick(4);
        chk("t3_done", done, 1);
        chk("t3_count", sample_count, 4);
`ifdef RF_STIM_GEN_CHECKSUM_EN
        chk("t3_checksum", checksum, 32'h0001_FFFE);
`endif
        tick();

        // Continuous ramp, abort while the sink is ready
        sb.push_back(ramp_w(0));
        sb.push_back(ramp_w(1));
        run(2'd0, '0, '0, 32'd0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_count", sample_count, 2);
        tick();
        chk("t4_done_pulse", done, 0);

        // Continuous noise, abort during a stall goes through FLUSH
        sb.push_back(64'h0002_0003_0000_0001);
        sb.push_back(64'h8001_8002_8000_8003);
        sb.push_back(64'h4003_4001_4000_4002);
        run(2'd2, '0, '0, 32'd0);
        tick(2);
        bus.out_ready = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_flush_busy", busy, 1);
        chk("t5_flush_valid", bus.out_valid, 1);
        chk("t5_flush_done", done, 0);
        chk("t5_flush_data", bus.out_data, 64'h4003_4001_4000_4002);
        tick();
        chk("t5_flush_hold", bus.out_data, 64'h4003_4001_4000_4002);
        bus.out_ready = 1'b1;
        tick();
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 0);
        chk("t5_valid", bus.out_valid, 0);
        chk("t5_count", sample_count, 3);
`ifdef RF_STIM_GEN_CHECKSUM_EN
        chk("t5_checksum", checksum, 32'h0000_C006);
`endif
        tick();

        // start together with abort in IDLE starts nothing
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_valid", bus.out_valid, 0);
        chk("t6_count", sample_count, 3);
        tick();
        chk("t6_done", done, 0);

        // Reset in the middle of a run
        sb.push_back(ramp_w(0));
        sb.push_back(ramp_w(1));
        run(2'd0, '0, '0, 32'd8);
        tick(2);
        rst_n = 1'b0;
        tick();
        chk("t7_data", bus.out_data, 0);
        chk("t7_valid", bus.out_valid, 0);
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_count", sample_count, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t7_no_done", done, 0);
        end

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_stim_gen.md
# rf_stim_gen

- Synthesizable, parametrised multi-channel ADC stimulus generator for the RF frontend.
- Produces ramp, triangle-tone, LFSR-noise or constant sample bursts on a valid/ready stream feeding `rf_frontend_top` `adc_data`/`adc_valid`/`adc_ready`, in simulation and on hardware.
- Holds data under backpressure, counts samples, supports bounded or continuous runs with clean abort, and reports completion.

## Interface
- `DATA_WIDTH`, 16: sample width per channel, 8..24.
- `PHASE_WIDTH`, 24: tone phase accumulator width, > `DATA_WIDTH`.
- `NUM_CH`, 1: parallel channels; must be 1, 2, 4 or 8.
- `LFSR_SEED`, 32'hACE1_0001: base LFSR seed; must be non-zero.
- `clk` in 1: system clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `start` in 1: pulse; begins a run when idle.
- `abort` in 1: pulse; ends a run after any pending beat is accepted.
- `mode` in 2: 0 ramp, 1 triangle tone, 2 LFSR noise, 3 constant (= `amplitude`).
- `phase_inc` in `PHASE_WIDTH`: tone phase step per beat.
- `amplitude` in `DATA_WIDTH`: signed tone scale / constant value.
- `num_samples` in 32: beats per run; 0 = continuous until abort.
- `out_data` out `NUM_CH*DATA_WIDTH`: channel k in bits [k*DW +: DW].
- `out_valid` out 1: beat present.
- `out_ready` in 1: sink accepts.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse at end of run.
- `sample_count` out 32: beats accepted in current/last run.
- `checksum` out 32: present only with `RF_STIM_GEN_CHECKSUM_EN`.

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE → RUN on `start && !abort`.
  - `mode`, `phase_inc`, `amplitude`, `num_samples` are latched; they are ignored during a run.
  - Phase accumulator, ramp counter and `sample_count` clear to 0.
  - Channel k LFSR reseeds to `LFSR_SEED ^ k`.
- Accept = `out_valid && out_ready`. On accept:
  - The next sample loads.
  - Accumulator += `phase_inc`; ramp += 1; LFSRs step once.
  - `sample_count` += 1.
- RUN → IDLE with `done` when the accepted beat makes `sample_count == num_samples` (`num_samples ≠ 0`).
- Abort handling:
  - RUN with `abort` and no stalled beat → IDLE with `done`.
  - RUN with `abort` and `out_valid && !out_ready` → FLUSH.
  - FLUSH → IDLE with `done` on accept.
  - Abort has priority over count completion on the same cycle; the result is the same.
- `start` is ignored while `busy`.
- `start` and `abort` together in IDLE: no run.
- Sample generation, per channel k:
  - Ramp: `ramp + k` mod 2^DW.
  - Tone phase: `acc + (k << (PW - log2 NUM_CH))`.
  - u = phase top DW bits; t = u[DW-1] ? ~{u[DW-2:0],0} : {u[DW-2:0],0}; s = t ^ 2^(DW-1), signed.
  - Output = (s × signed `amplitude`)[2DW-2:DW-1], i.e. arithmetic >>> (DW-1), truncated.
  - Noise: Galois LFSR, polynomial 0x80200003; output is the low DW bits.
- Accumulator and ramp wrap modulo their widths silently.

## Timing
- Reset values: `out_data` 0, `out_valid` 0, `busy` 0, `done` 0, `sample_count` 0, `checksum` 0, state IDLE.
- `start` sampled at edge N: `out_valid`=1 with sample 0 from N+1, so latency is 1 cycle.
- With `out_ready` held high: one beat per cycle, no bubbles.
- Stall: `out_data` is stable while `out_valid && !out_ready`; `out_valid` never drops with a beat pending.
- Final accept at edge M:
  - `out_valid`=0 and `busy`=0 from M+1.
  - `done`=1 for cycle M+1 only.
  - `sample_count` holds until the next `start`.
- `rst_n` low mid-run: all outputs return to reset values at the next edge; no `done`.

## Configuration
- `RF_STIM_GEN_CHECKSUM_EN` defined:
  - `checksum` port exists.
  - Cleared on `start`.
  - On each accept, += zero-extended channel-0 sample, mod 2^32.
- Undefined: the port and logic are absent; all other behaviour is identical.

## Test plan
- Ramp, NUM_CH=1, `num_samples`=4, `out_ready`=1 → `out_data` 0,1,2,3 on cycles N+1..N+4; `done` at N+5; `sample_count`=4; `checksum`=6.
- Same run, `out_ready` low 3 cycles at beat 1 → `out_data`=1 held stable 4 cycles; total 4 beats; `done` one cycle after the last accept.
- Tone, DW=16, PW=24, `phase_inc`=0x400000, `amplitude`=0x7FFF, `num_samples`=4 → 0x8001, 0x0000, 0x7FFE, 0xFFFF.
- NUM_CH=4 ramp → first beat `out_data`=0x0003_0002_0001_0000.
- Continuous noise with `abort` during a stall → FLUSH; the stalled beat is accepted; then `done` and IDLE.
- `start`+`abort` in IDLE → `busy` stays 0.
- `rst_n` low at beat 2 → outputs zero next edge; no `done`.
